// File: rtl/tdc_interval_calc.sv
// -----------------------------------------------------------------------------
// tdc_interval_calc
// Converts a start/stop fine-bin pair plus a coarse clock-cycle count into a
// time interval expressed in fine bins, with a valid/ready result handshake.
//
// State table:
//   state   | meaning
//   IDLE    | measurement disabled, all hits ignored
//   ARMED   | waiting for a start hit
//   RUNNING | start seen, coarse counter running, waiting for stop
//   CALC    | one cycle: form interval and register the result
//   OUT     | result presented, held until wValid & wReady
//
// Ports:
//   wClk, wRst            clock, synchronous active-high reset
//   wEnable               measurement enable
//   wStartHit/wStartBin   start edge pulse and its fine bin
//   wStopHit/wStopBin     stop edge pulse and its fine bin
//   wReady                downstream accepts the result
//   wInterval             interval in fine bins
//   wValid                result (interval/overflow/error) valid
//   wOverflow, wError     result is a timeout/saturated, result was negative
//   wMissed               saturating count of hits ignored while busy
//   wBusy                 high in RUNNING, CALC and OUT
// -----------------------------------------------------------------------------
module tdc_interval_calc #(
    parameter int BITS_DECO   = 8,
    parameter int BITS_COARSE = 12,
    parameter int BITS_OUT    = 24,
    parameter int CLK_BINS    = 200
) (
    input  logic                 wClk,
    input  logic                 wRst,
    input  logic                 wEnable,
    input  logic                 wStartHit,
    input  logic [BITS_DECO-1:0] wStartBin,
    input  logic                 wStopHit,
    input  logic [BITS_DECO-1:0] wStopBin,
    input  logic                 wReady,
    output logic [BITS_OUT-1:0]  wInterval,
    output logic                 wValid,
    output logic                 wOverflow,
    output logic                 wError,
    output logic [7:0]           wMissed,
    output logic                 wBusy
);

    typedef enum logic [2:0] {IDLE, ARMED, RUNNING, CALC, OUT} state_t;

    // One bit of headroom beyond the signed BITS_OUT+1 result so that a
    // positive value wider than BITS_OUT can be detected and saturated.
    localparam int WC = BITS_OUT + 2;
    localparam logic [BITS_COARSE-1:0] COARSE_MAX = '1;

    state_t                 state;
    logic [BITS_COARSE-1:0] coarse_cnt;
    logic [BITS_COARSE:0]   coarse_cap;   // can reach 2^BITS_COARSE on a late stop
    logic [BITS_DECO-1:0]   start_bin;
    logic [BITS_DECO-1:0]   stop_bin;
    logic                   timeout;

    logic [WC-1:0] diff;
    logic          neg;
    logic          too_wide;
    logic [1:0]    miss_inc;
    logic [8:0]    miss_sum;
    logic [7:0]    miss_next;

    always_comb begin
        diff     = WC'(coarse_cap) * WC'(CLK_BINS) + WC'(start_bin) - WC'(stop_bin);
        neg      = diff[WC-1];
        too_wide = |diff[WC-2:BITS_OUT];
    end

    // Start hits are ignored while RUNNING; in CALC/OUT every hit is ignored.
    always_comb begin
        miss_inc = 2'd0;
        case (state)
            RUNNING:   miss_inc = {1'b0, wStartHit};
            CALC, OUT: miss_inc = 2'(wStartHit) + 2'(wStopHit);
            default:   miss_inc = 2'd0;
        endcase
        miss_sum  = {1'b0, wMissed} + 9'(miss_inc);
        miss_next = miss_sum[8] ? 8'hFF : miss_sum[7:0];
    end

    assign wBusy = (state == RUNNING) || (state == CALC) || (state == OUT);

    always_ff @(posedge wClk) begin
        if (wRst) begin
            state      <= IDLE;
            coarse_cnt <= '0;
            coarse_cap <= '0;
            start_bin  <= '0;
            stop_bin   <= '0;
            timeout    <= 1'b0;
            wInterval  <= '0;
            wValid     <= 1'b0;
            wOverflow  <= 1'b0;
            wError     <= 1'b0;
            wMissed    <= '0;
        end else begin
            wMissed <= miss_next;
            case (state)
                IDLE: begin
                    if (wEnable) state <= ARMED;
                end
                ARMED: begin
                    if (!wEnable) begin
                        state <= IDLE;
                    end else if (wStartHit) begin
                        start_bin  <= wStartBin;
                        coarse_cnt <= '0;
                        coarse_cap <= '0;
                        timeout    <= 1'b0;
                        if (wStopHit) begin
                            stop_bin <= wStopBin;
                            state    <= CALC;
                        end else begin
                            state <= RUNNING;
                        end
                    end
                end
                RUNNING: begin
                    if (!wEnable) begin
                        state <= IDLE;
                    end else begin
                        coarse_cnt <= coarse_cnt + BITS_COARSE'(1);
                        if (wStopHit) begin
                            stop_bin   <= wStopBin;
                            // counts edges from start sample to stop sample
                            coarse_cap <= {1'b0, coarse_cnt} + (BITS_COARSE + 1)'(1);
                            state      <= CALC;
                        end else if (coarse_cnt == COARSE_MAX) begin
                            timeout <= 1'b1;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    wValid <= 1'b1;
                    if (timeout) begin
                        wInterval <= '1;
                        wOverflow <= 1'b1;
                        wError    <= 1'b0;
                    end else if (neg) begin
                        wInterval <= '0;
                        wOverflow <= 1'b0;
                        wError    <= 1'b1;
                    end else if (too_wide) begin
                        wInterval <= '1;
                        wOverflow <= 1'b1;
                        wError    <= 1'b0;
                    end else begin
                        wInterval <= diff[BITS_OUT-1:0];
                        wOverflow <= 1'b0;
                        wError    <= 1'b0;
                    end
                    state <= OUT;
                end
                OUT: begin
                    if (wReady) begin
                        wValid <= 1'b0;
                        state  <= wEnable ? ARMED : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
